// File: rtl/ext_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_pkg
// Description : Shared definitions for the external-bus to AXI4-Lite bridge:
//               bridge state encoding, AXI response codes, and the NOP word
//               returned to the core when a transaction times out.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_bus_pkg;

  // Bridge transaction states (explicit 3-bit encoding).
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5,
    DRAIN   = 3'd6
  } bridge_state_e;

  // AXI response codes.
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  // RISC-V "addi x0,x0,0": harmless word handed back on a timed-out access.
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

endpackage : ext_bus_pkg
`default_nettype wire

// File: rtl/ext_axil_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ext_axil_bridge
// Description : Converts a simple valid/ready core request (one outstanding
//               access) into AXI4-Lite read or write transactions.
//               Core side : ext_valid, ext_instruction, ext_address,
//                           ext_write_data, ext_write_strobe -> ext_ready,
//                           ext_read_data (registered, valid with ext_ready)
//               AXI side  : AW/W/B and AR/R channels (m_* ports)
//               Status    : bus_error, sticky until reset
//               Optional  : define EXT_AXIL_BRIDGE_TIMEOUT_EN to enable the
//                           per-transaction wait timeout (TIMEOUT_CYCLES) and
//                           the DRAIN state that absorbs late responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_axil_bridge
  import ext_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // core request side
  input  logic        ext_valid,
  input  logic        ext_instruction,
  input  logic [31:0] ext_address,
  input  logic [31:0] ext_write_data,
  input  logic [3:0]  ext_write_strobe,
  output logic        ext_ready,
  output logic [31:0] ext_read_data,
  // AXI4-Lite write address
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  // AXI4-Lite write data
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  // AXI4-Lite write response
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  // AXI4-Lite read address
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  // AXI4-Lite read data
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  // status
  output logic        bus_error
);

  bridge_state_e r_state;
  bridge_state_e w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_is_write;
  logic        r_arvalid;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_bus_error;

  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_r_hs;
  logic w_b_hs;
  logic w_wr_req_done;
  logic w_waiting;
  logic w_to_done;
  logic w_drain_done;
  logic w_timeout;

  // AXI4-Lite carries no instruction/data qualifier on this port set.
  logic w_unused_instr;
  assign w_unused_instr = ext_instruction;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign m_rready  = (r_state == RD_DATA) || (r_state == DRAIN);
  assign m_bready  = (r_state == WR_RESP) || (r_state == DRAIN);

  assign w_ar_hs   = r_arvalid & m_arready;
  assign w_aw_hs   = r_awvalid & m_awready;
  assign w_w_hs    = r_wvalid  & m_wready;
  assign w_r_hs    = m_rvalid  & m_rready;
  assign w_b_hs    = m_bvalid  & m_bready;

  // Each write channel is finished when it already handshook or does so now.
  assign w_wr_req_done = (~r_awvalid | m_awready) & (~r_wvalid | m_wready);

  assign w_waiting = (r_state == RD_ADDR) || (r_state == RD_DATA) ||
                     (r_state == WR_REQ)  || (r_state == WR_RESP);

  // A response completing in the limit cycle still wins over the timeout.
  assign w_to_done = ((r_state == RD_DATA) && m_rvalid) ||
                     ((r_state == WR_RESP) && m_bvalid);

  // Leave DRAIN only once every request channel is accepted and the
  // matching response has been absorbed.
  assign w_drain_done = (r_is_write ? m_bvalid : m_rvalid) &
                        ~r_arvalid & ~r_awvalid & ~r_wvalid;

  // --------------------------------------------------------------------------
  // Optional wait-cycle timeout
  // --------------------------------------------------------------------------
`ifdef EXT_AXIL_BRIDGE_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (w_waiting) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_timeout = w_waiting && !w_to_done &&
                     (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (ext_valid) begin
          w_next = (|ext_write_strobe) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (w_timeout)    w_next = DRAIN;
        else if (w_ar_hs) w_next = RD_DATA;
      end
      RD_DATA: begin
        if (m_rvalid)       w_next = DONE;
        else if (w_timeout) w_next = DRAIN;
      end
      WR_REQ: begin
        if (w_timeout)          w_next = DRAIN;
        else if (w_wr_req_done) w_next = WR_RESP;
      end
      WR_RESP: begin
        if (m_bvalid)       w_next = DONE;
        else if (w_timeout) w_next = DRAIN;
      end
      DONE: begin
        w_next = IDLE;
      end
      DRAIN: begin
        if (w_drain_done) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch and AXI VALID tracking
  // --------------------------------------------------------------------------
  // VALIDs are set only when a request is accepted and dropped only by their
  // own handshake, so they stay stable across a timeout into DRAIN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_is_write <= 1'b0;
      r_arvalid  <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
    end else if ((r_state == IDLE) && ext_valid) begin
      r_addr     <= ext_address;
      r_wdata    <= ext_write_data;
      r_wstrb    <= ext_write_strobe;
      r_is_write <= |ext_write_strobe;
      r_arvalid  <= ~(|ext_write_strobe);
      r_awvalid  <= |ext_write_strobe;
      r_wvalid   <= |ext_write_strobe;
    end else begin
      if (w_ar_hs) r_arvalid <= 1'b0;
      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs)  r_wvalid  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Core response and status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_bus_error <= 1'b0;
    end else begin
      // DONE lasts exactly one cycle, so this is a single-cycle pulse.
      r_ready <= (w_next == DONE) || w_timeout;

      if ((r_state == RD_DATA) && m_rvalid) begin
        r_rdata <= m_rdata;
      end else if (w_timeout) begin
        r_rdata <= c_NOP_INSTR;
      end

      if ((w_r_hs && (m_rresp != c_RESP_OKAY)) ||
          (w_b_hs && (m_bresp != c_RESP_OKAY)) ||
          w_timeout) begin
        r_bus_error <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ext_ready     = r_ready;
  assign ext_read_data = r_rdata;
  assign bus_error     = r_bus_error;

  assign m_arvalid     = r_arvalid;
  assign m_araddr      = r_addr;
  assign m_awvalid     = r_awvalid;
  assign m_awaddr      = r_addr;
  assign m_wvalid      = r_wvalid;
  assign m_wdata       = r_wdata;
  assign m_wstrb       = r_wstrb;

endmodule : ext_axil_bridge
`default_nettype wire
